// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative signed/unsigned multiply/divide unit with Hi/Lo registers
// Optional MDU_EARLY_TERM_EN: multiply stops once the remaining multiplier bits are all zero.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic             divby0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DZ} state_t;

    state_t             state;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplr;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;

    logic               signed_op;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [2*WIDTH-1:0] mul_acc;
    logic [WIDTH:0]     rem_sh;
    logic               ge;
    logic [WIDTH-1:0]   rem_sub;
    logic [2*WIDTH-1:0] div_acc;
    logic               mul_last;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        signed_op = ~op[0];
        abs_a     = (signed_op && src_a[WIDTH-1]) ? -src_a : src_a;
        abs_b     = (signed_op && src_b[WIDTH-1]) ? -src_b : src_b;

        mul_acc   = acc + (mplr[0] ? mcand : '0);

        // Shifted partial remainder can need WIDTH+1 bits; a successful
        // subtraction always fits back into WIDTH bits.
        rem_sh    = acc[2*WIDTH-1:WIDTH-1];
        ge        = rem_sh >= {1'b0, mplr};
        rem_sub   = rem_sh[WIDTH-1:0] - mplr;
        div_acc   = {(ge ? rem_sub : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], ge};

`ifdef MDU_EARLY_TERM_EN
        mul_last  = (mplr[WIDTH-1:1] == '0) || (cnt == LAST);
`else
        mul_last  = (cnt == LAST);
`endif

        prod_fix  = neg_res ? -acc : acc;
        quo_fix   = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix   = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            mcand   <= '0;
            mplr    <= '0;
            acc     <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            divby0  <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done   <= 1'b0;
            divby0 <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div  <= op[1];
                        neg_res <= signed_op & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                        neg_rem <= signed_op & src_a[WIDTH-1];
                        mplr    <= abs_b;
                        mcand   <= {{WIDTH{1'b0}}, abs_a};
                        acc     <= op[1] ? {{WIDTH{1'b0}}, abs_a} : '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= (op[1] && src_b == '0) ? DZ : RUN;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (is_div) begin
                        acc <= div_acc;
                        if (cnt == LAST) state <= FIX;
                    end else begin
                        acc   <= mul_acc;
                        mcand <= mcand << 1;
                        mplr  <= mplr >> 1;
                        if (mul_last) state <= FIX;
                    end
                end
                FIX: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                DZ: begin
                    done   <= 1'b1;
                    divby0 <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit (WIDTH=32)
module tb_mult_div_unit;
    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a, src_b;
    logic        busy, done, divby0;
    logic [31:0] hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          e0;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   edges  = 0;
    int   checks = 0;
    int   errors = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset_n), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
        .divby0(divby0), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Multiply latency in edges after the start edge.
    function automatic int mlat(input logic [1:0] o, input logic [31:0] b);
        logic [31:0] m;
        int steps;
        m = (o == MULT && b[31]) ? -b : b;
        steps = 32;
`ifdef MDU_EARLY_TERM_EN
        steps = 1;
        for (int i = 0; i < 32; i++) if (m[i]) steps = i + 1;
`endif
        return steps + 1;
    endfunction

    always @(negedge clk) begin
        if (reset_n && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending operation");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("hi", 64'(hi), 64'(e.hi));
                chk("lo", 64'(lo), 64'(e.lo));
                chk("divby0", 64'(divby0), 64'(e.dz));
                chk("latency", 64'(edges - e.e0), 64'(e.lat));
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input logic dz,
                         input int lat, input bit expect_done);
        exp_t e;
        op = o; src_a = a; src_b = b; start = 1'b1;
        if (expect_done) begin
            e.hi = eh; e.lo = el; e.dz = dz; e.e0 = edges + 1; e.lat = lat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        src_a = $urandom();
        src_b = $urandom();
        op    = 2'($urandom_range(3));
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) return;
        end
        checks++;
        errors++;
        $display("FAIL timeout: got no done within 200 cycles expected done");
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el);
        int lat;
        lat = o[1] ? 33 : mlat(o, b);
        issue(o, a, b, eh, el, 1'b0, lat, 1'b1);
        wait_done();
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_divby0", 64'(divby0), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        run(MULT,  32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        // issued in the done cycle of the previous op
        run(DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run(DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run(DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003);
        run(DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF);
        run(MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
        run(MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run(MULTU, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 32'h0000_000F);
        run(MULTU, 32'h0000_1234, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);

        // preload hi=0x1234 lo=0x5678, then divide by zero leaves them untouched
        run(DIVU,  32'h5678_1234, 32'h0001_0000, 32'h0000_1234, 32'h0000_5678);
        issue(DIVU, 32'h0000_0010, 32'h0000_0000, 32'h0000_1234, 32'h0000_5678, 1'b1, 1, 1'b1);
        wait_done();
        issue(DIV, 32'h8000_0000, 32'h0000_0000, 32'h0000_1234, 32'h0000_5678, 1'b1, 1, 1'b1);
        wait_done();

        // start pulse during busy must not disturb the running multiply
        issue(MULTU, 32'h0000_0002, 32'h0000_0003, 32'h0, 32'h6, 1'b0, mlat(MULTU, 32'h3), 1'b1);
        start = 1'b1; op = DIVU; src_a = 32'h99; src_b = 32'h0;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_hold", 64'(busy), 64'd1);
        wait_done();

        // abort a multiply by reset at edge 10; no done may follow
        @(negedge clk);
        issue(MULTU, 32'h0000_0002, 32'h8000_0002, 32'h0, 32'h0, 1'b0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; op = MULT; src_a = 32'h7; src_b = 32'h9;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("ignored_start_busy", 64'(busy), 64'd1);
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("idle_after_abort", 64'(busy), 64'd0);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
